// File: rtl/pc_seq_if.sv
// ---------------------------------------------------------------------------
// pc_seq_if
// Signal bundle between the pc_sequencer and its surroundings (instruction
// memory, instruction register, jump/branch resolution, data memory).
//
// Control semantics (one place): there is no valid/ready pair here. start is
// a level that is only sampled in IDLE; jump_valid/branch_taken and their
// targets are sampled only on the edge leaving EXEC; mem_busy is sampled only
// on edges leaving MEM. All outputs are registered or decoded from state.
//
// Signals:
//   start          in   1  leave IDLE and begin fetching
//   ir_opcode      in   6  IR[31:26], valid from DECODE onward
//   jump_valid     in   1  jump redirect resolved (EXEC only)
//   jump_target    in   9  jump destination
//   branch_taken   in   1  branch resolved taken (EXEC only)
//   branch_target  in   9  branch destination
//   mem_busy       in   1  data memory not ready (MEM only)
//   pc             out  9  program counter
//   inst_load      out  1  IR capture enable (FETCH)
//   mem_phase      out  1  high in MEM
//   reg_write_en   out  1  register-file write pulse (WB)
//   state          out  3  FSM state, debug
//   halted         out  1  high in HALT
//   trap           out  1  PC-overflow trap flag
//   instr_count    out 16  retired-instruction counter
// ---------------------------------------------------------------------------
interface pc_seq_if;
    logic        start;
    logic [5:0]  ir_opcode;
    logic        jump_valid;
    logic [8:0]  jump_target;
    logic        branch_taken;
    logic [8:0]  branch_target;
    logic        mem_busy;
    logic [8:0]  pc;
    logic        inst_load;
    logic        mem_phase;
    logic        reg_write_en;
    logic [2:0]  state;
    logic        halted;
    logic        trap;
    logic [15:0] instr_count;

    // master: environment driving the sequencer
    modport master (
        output start, ir_opcode, jump_valid, jump_target,
               branch_taken, branch_target, mem_busy,
        input  pc, inst_load, mem_phase, reg_write_en, state,
               halted, trap, instr_count
    );

    // slave: the sequencer itself
    modport slave (
        input  start, ir_opcode, jump_valid, jump_target,
               branch_taken, branch_target, mem_busy,
        output pc, inst_load, mem_phase, reg_write_en, state,
               halted, trap, instr_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Multi-cycle control FSM owning the 9-bit program counter. Each instruction
// walks FETCH -> DECODE -> EXEC -> (MEM) -> WB; jumps/branches captured in
// EXEC are applied at WB, MEM stalls while mem_busy, opcode 6'h3F halts.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   pc_seq_if.slave (see pc_seq_if.sv for the signal list)
//
// Optional feature macro: PC_SEQ_WRAP_TRAP_EN
//   defined   : WB at pc==511 without redirect goes to HALT and sets trap
//   undefined : pc wraps 511 -> 0, trap tied low
// ---------------------------------------------------------------------------
module pc_sequencer (
    input  logic     clk,
    input  logic     rst,
    pc_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  pc_q, pc_d;
    logic [8:0]  redir_pc_q, redir_pc_d;
    logic        redir_pend_q, redir_pend_d;
    logic [15:0] count_q, count_d;
    logic        rwe_q, rwe_d;
`ifdef PC_SEQ_WRAP_TRAP_EN
    logic        trap_q, trap_d;
`endif

    logic op_skip_mem;   // j, jr, jal: no data-memory phase
    logic op_no_write;   // j, jr: no register write
    assign op_skip_mem = (bus.ir_opcode == 6'd1) || (bus.ir_opcode == 6'd2) ||
                         (bus.ir_opcode == 6'd3);
    assign op_no_write = (bus.ir_opcode == 6'd1) || (bus.ir_opcode == 6'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= 9'd0;
            redir_pc_q   <= 9'd0;
            redir_pend_q <= 1'b0;
            count_q      <= 16'd0;
            rwe_q        <= 1'b0;
`ifdef PC_SEQ_WRAP_TRAP_EN
            trap_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redir_pc_q   <= redir_pc_d;
            redir_pend_q <= redir_pend_d;
            count_q      <= count_d;
            rwe_q        <= rwe_d;
`ifdef PC_SEQ_WRAP_TRAP_EN
            trap_q       <= trap_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_pc_d   = redir_pc_q;
        redir_pend_d = redir_pend_q;
        count_d      = count_q;
        // reg_write_en is registered: it is computed on the edge entering WB
        // so the output has no combinational path from ir_opcode.
        rwe_d        = 1'b0;
`ifdef PC_SEQ_WRAP_TRAP_EN
        trap_d       = trap_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = (bus.ir_opcode == 6'h3F) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                // Jump has priority over a simultaneously taken branch.
                if (bus.jump_valid) begin
                    redir_pc_d   = bus.jump_target;
                    redir_pend_d = 1'b1;
                end else if (bus.branch_taken) begin
                    redir_pc_d   = bus.branch_target;
                    redir_pend_d = 1'b1;
                end
                if (op_skip_mem) begin
                    state_d = S_WB;
                    rwe_d   = !op_no_write;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_MEM: begin
                if (!bus.mem_busy) begin
                    state_d = S_WB;
                    rwe_d   = !op_no_write;
                end
            end
            S_WB: begin
                count_d      = count_q + 16'd1;
                redir_pend_d = 1'b0;
                state_d      = S_FETCH;
                if (redir_pend_q) begin
                    pc_d = redir_pc_q;
                end else begin
`ifdef PC_SEQ_WRAP_TRAP_EN
                    if (pc_q == 9'd511) begin
                        state_d = S_HALT;
                        trap_d  = 1'b1;
                    end else begin
                        pc_d = pc_q + 9'd1;
                    end
`else
                    pc_d = pc_q + 9'd1;
`endif
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.pc           = pc_q;
    assign bus.inst_load    = (state_q == S_FETCH);
    assign bus.mem_phase    = (state_q == S_MEM);
    assign bus.reg_write_en = rwe_q;
    assign bus.state        = state_q;
    assign bus.halted       = (state_q == S_HALT);
    assign bus.instr_count  = count_q;
`ifdef PC_SEQ_WRAP_TRAP_EN
    assign bus.trap         = trap_q;
`else
    assign bus.trap         = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_seq_if bus();

    pc_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

`ifdef PC_SEQ_WRAP_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    int checks = 0;
    int passed = 0;

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        bus.start         = 1'b0;
        bus.ir_opcode     = 6'd0;
        bus.jump_valid    = 1'b0;
        bus.jump_target   = 9'd0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 9'd0;
        bus.mem_busy      = 1'b0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // ---------------- driver ----------------
    // Entered with the DUT in FETCH. Presents the EXEC redirect in the third
    // cycle and nbusy busy cycles in MEM; with junk set, every other input is
    // randomized where it must be ignored. Returns the number of cycles until
    // FETCH or HALT is seen again, plus the observed write and MEM cycles.
    task automatic drive_instr(input logic [5:0] op, input logic jv, input logic [8:0] jt,
                               input logic bt, input logic [8:0] btg, input int nbusy,
                               input bit junk, output int ncyc, output int nrwe,
                               output int nmem);
        int cyc;
        cyc  = 0;
        nrwe = 0;
        nmem = 0;
        bus.ir_opcode = op;
        while (1) begin
            if (junk) begin
                bus.start         = 1'($urandom);
                bus.jump_valid    = 1'($urandom);
                bus.jump_target   = 9'($urandom);
                bus.branch_taken  = 1'($urandom);
                bus.branch_target = 9'($urandom);
                bus.mem_busy      = 1'($urandom);
            end else begin
                bus.jump_valid    = 1'b0;
                bus.branch_taken  = 1'b0;
                bus.mem_busy      = 1'b0;
            end
            if (cyc == 2) begin
                bus.jump_valid    = jv;
                bus.jump_target   = jt;
                bus.branch_taken  = bt;
                bus.branch_target = btg;
            end
            if (cyc >= 3) bus.mem_busy = ((cyc - 3) < nbusy);
            step();
            cyc++;
            nrwe += int'(bus.reg_write_en);
            nmem += int'(bus.mem_phase);
            if (bus.state == 3'd1 || bus.state == 3'd6 || cyc >= 40) break;
        end
        ncyc = cyc;
        quiet_inputs();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [5:0] op;
        logic       jv;
        logic [8:0] jt;
        logic       bt;
        logic [8:0] btg;
        int         nbusy;
        bit         junk;
        logic [8:0] exp_pc;
        int         exp_rwe;
        int         exp_cyc;
        int         exp_mem;
        logic [2:0] exp_state;
    } vec_t;

    vec_t tbl[8];

    // ---------------- reference model state ----------------
    int pc_m;
    int cnt_m;

    initial begin
        int ncyc, nrwe, nmem;
        logic [5:0] op;
        logic jv, bt;
        logic [8:0] jt, btg;
        int nbusy, exp_cyc, exp_mem, exp_rwe, nxt;
        bit exp_halt;

        //         op     jv  jt      bt  btg     busy junk pc      rwe cyc mem st
        tbl[0] = '{6'd0,  0, 9'h000, 0, 9'h000, 0,   0,  9'h001, 1,  5,  1,  3'd1};
        tbl[1] = '{6'd0,  0, 9'h000, 0, 9'h000, 0,   0,  9'h002, 1,  5,  1,  3'd1};
        tbl[2] = '{6'd1,  1, 9'h040, 0, 9'h000, 0,   0,  9'h040, 0,  4,  0,  3'd1};
        tbl[3] = '{6'd3,  1, 9'h040, 0, 9'h000, 0,   0,  9'h040, 1,  4,  0,  3'd1};
        tbl[4] = '{6'd0,  1, 9'h010, 1, 9'h020, 0,   0,  9'h010, 1,  5,  1,  3'd1};
        tbl[5] = '{6'd0,  0, 9'h000, 0, 9'h000, 3,   1,  9'h011, 1,  8,  4,  3'd1};
        tbl[6] = '{6'd2,  0, 9'h000, 1, 9'h1FF, 0,   0,  9'h1FF, 0,  4,  0,  3'd1};
        tbl[7] = TRAP_EN ? '{6'd0, 0, 9'h000, 0, 9'h000, 0, 0, 9'h1FF, 1, 5, 1, 3'd6}
                         : '{6'd0, 0, 9'h000, 0, 9'h000, 0, 0, 9'h000, 1, 5, 1, 3'd1};

        // ---- reset state ----
        do_reset();
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_pc", 32'(bus.pc), 32'd0);
        chk("rst_count", 32'(bus.instr_count), 32'd0);
        chk("rst_flags", {28'd0, bus.inst_load, bus.mem_phase, bus.reg_write_en, bus.halted}, 32'd0);
        chk("rst_trap", 32'(bus.trap), 32'd0);

        // ---- IDLE holds without start, ignores redirect/busy noise ----
        bus.jump_valid = 1'b1;
        bus.mem_busy   = 1'b1;
        repeat (3) step();
        quiet_inputs();
        chk("idle_hold", 32'(bus.state), 32'd0);
        do_start();
        chk("start_fetch", 32'(bus.state), 32'd1);
        chk("start_inst_load", 32'(bus.inst_load), 32'd1);

        // ---- directed table ----
        for (int i = 0; i < 8; i++) begin
            drive_instr(tbl[i].op, tbl[i].jv, tbl[i].jt, tbl[i].bt, tbl[i].btg,
                        tbl[i].nbusy, tbl[i].junk, ncyc, nrwe, nmem);
            chk($sformatf("tbl%0d_cycles", i), 32'(ncyc), 32'(tbl[i].exp_cyc));
            chk($sformatf("tbl%0d_rwe", i), 32'(nrwe), 32'(tbl[i].exp_rwe));
            chk($sformatf("tbl%0d_mem", i), 32'(nmem), 32'(tbl[i].exp_mem));
            chk($sformatf("tbl%0d_pc", i), 32'(bus.pc), 32'(tbl[i].exp_pc));
            chk($sformatf("tbl%0d_state", i), 32'(bus.state), 32'(tbl[i].exp_state));
            chk($sformatf("tbl%0d_count", i), 32'(bus.instr_count), 32'(i + 1));
        end
        chk("wrap_trap", 32'(bus.trap), 32'(TRAP_EN));
        chk("wrap_halted", 32'(bus.halted), 32'(TRAP_EN));
        if (!TRAP_EN) chk("wrap_inst_load", 32'(bus.inst_load), 32'd1);

        // ---- halt: pc and count frozen, start ignored, rst exits ----
        do_reset();
        do_start();
        drive_instr(6'd0, 0, 9'd0, 0, 9'd0, 0, 0, ncyc, nrwe, nmem);
        drive_instr(6'h3F, 0, 9'd0, 0, 9'd0, 0, 0, ncyc, nrwe, nmem);
        chk("halt_cycles", 32'(ncyc), 32'd2);
        chk("halt_rwe", 32'(nrwe), 32'd0);
        chk("halt_state", 32'(bus.state), 32'd6);
        chk("halt_halted", 32'(bus.halted), 32'd1);
        chk("halt_pc", 32'(bus.pc), 32'd1);
        chk("halt_count", 32'(bus.instr_count), 32'd1);
        for (int k = 0; k < 6; k++) begin
            bus.start      = 1'b1;
            bus.jump_valid = 1'($urandom);
            bus.mem_busy   = 1'($urandom);
            step();
        end
        quiet_inputs();
        chk("halt_absorb_state", 32'(bus.state), 32'd6);
        chk("halt_absorb_pc", 32'(bus.pc), 32'd1);
        do_reset();
        chk("halt_rst_state", 32'(bus.state), 32'd0);
        chk("halt_rst_pc", 32'(bus.pc), 32'd0);

        // ---- rst in WB discards the captured redirect ----
        do_start();
        bus.ir_opcode = 6'd1;
        step();                       // DECODE
        step();                       // EXEC
        bus.jump_valid  = 1'b1;
        bus.jump_target = 9'h055;
        step();                       // WB with redirect pending
        chk("rstwb_state", 32'(bus.state), 32'd5);
        quiet_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstwb_pc", 32'(bus.pc), 32'd0);
        chk("rstwb_idle", 32'(bus.state), 32'd0);
        do_start();
        drive_instr(6'd0, 0, 9'd0, 0, 9'd0, 0, 0, ncyc, nrwe, nmem);
        chk("rstwb_next_pc", 32'(bus.pc), 32'd1);

        // ---- randomized against the instruction-level model ----
        do_reset();
        do_start();
        pc_m  = 0;
        cnt_m = 0;
        for (int n = 0; n < 80; n++) begin
            op    = ($urandom_range(0, 3) < 3) ? 6'($urandom_range(0, 3))
                                               : 6'($urandom_range(4, 62));
            jv    = ($urandom_range(0, 3) == 0);
            bt    = ($urandom_range(0, 3) == 0);
            jt    = ($urandom_range(0, 2) == 0) ? 9'd511 : 9'($urandom);
            btg   = ($urandom_range(0, 2) == 0) ? 9'd511 : 9'($urandom);
            nbusy = $urandom_range(0, 3);

            exp_cyc  = (op >= 6'd1 && op <= 6'd3) ? 4 : 5 + nbusy;
            exp_mem  = (op >= 6'd1 && op <= 6'd3) ? 0 : nbusy + 1;
            exp_rwe  = (op == 6'd1 || op == 6'd2) ? 0 : 1;
            exp_halt = 1'b0;
            if (jv)               nxt = int'(jt);
            else if (bt)          nxt = int'(btg);
            else if (pc_m == 511 && TRAP_EN) begin
                nxt      = 511;
                exp_halt = 1'b1;
            end else              nxt = (pc_m + 1) % 512;
            cnt_m = (cnt_m + 1) % 65536;

            drive_instr(op, jv, jt, bt, btg, nbusy, 1'b1, ncyc, nrwe, nmem);
            chk($sformatf("rnd%0d_cycles", n), 32'(ncyc), 32'(exp_cyc));
            chk($sformatf("rnd%0d_rwe", n), 32'(nrwe), 32'(exp_rwe));
            chk($sformatf("rnd%0d_mem", n), 32'(nmem), 32'(exp_mem));
            chk($sformatf("rnd%0d_pc", n), 32'(bus.pc), 32'(nxt));
            chk($sformatf("rnd%0d_count", n), 32'(bus.instr_count), 32'(cnt_m));
            chk($sformatf("rnd%0d_halted", n), 32'(bus.halted), 32'(exp_halt));
            chk($sformatf("rnd%0d_trap", n), 32'(bus.trap), 32'(exp_halt));
            pc_m = nxt;
            if (exp_halt || bus.state != 3'd1) begin
                do_reset();
                do_start();
                pc_m  = 0;
                cnt_m = 0;
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Hard time limit so a wedged run still ends with a report.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("%0d/%0d checks passed", passed, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
